// File: rtl/i2c_cmd_arbiter_pkg.sv
// Shared types for the I2C command arbiter and the request manager it feeds.
package i2c_cmd_arbiter_pkg;

  // Burst count width; the request manager decodes the same width.
  localparam int BURST_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    DATA    = 2'd2,
    RELEASE = 2'd3
  } t_arb_states;

  // One command as presented on the manager CMD FIFO port.
  typedef struct packed {
    logic                   we;
    logic                   sccb_mode;
    logic [6:0]             addr_slave;
    logic [7:0]             addr_reg;
    logic [BURST_WIDTH-1:0] burst_num;
  } t_i2c_cmd;

endpackage

// File: rtl/i2c_cmd_arbiter_rr_pick.sv
// Round-robin priority pick: first set request at or above ptr, wrapping.
module rr_priority_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  // Walk the requests starting at ptr; the first hit wins.
  always_comb begin
    int k;
    k      = 0;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = (int'(ptr) + i) % NUM_REQ;
      if (!any && req[k]) begin
        any       = 1'b1;
        onehot[k] = 1'b1;
        idx       = ID_W'(k);
      end
    end
  end

endmodule

// File: rtl/i2c_cmd_arbiter.sv
// Round-robin arbiter sharing one I2C request manager between NUM_REQ
// requesters. The grant is held for a whole transaction (command plus all
// data beats, or an abort) and is followed by a one-cycle RELEASE so that
// an owner cannot re-grab the manager back to back.
//
// Handshakes: a transfer happens on a cycle where valid and ready are both
// high; valid, once raised, holds until that cycle. ready/valid towards
// non-granted requesters is always 0.
module i2c_cmd_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int BURST_WIDTH = i2c_cmd_arbiter_pkg::BURST_WIDTH,
  parameter int ID_W        = $clog2(NUM_REQ)
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic [NUM_REQ-1:0]             i_req_valid,
  input  logic [NUM_REQ-1:0]             i_req_we,
  input  logic [NUM_REQ-1:0]             i_req_sccb_mode,
  input  logic [NUM_REQ*7-1:0]           i_req_addr_slave,
  input  logic [NUM_REQ*8-1:0]           i_req_addr_reg,
  input  logic [NUM_REQ*BURST_WIDTH-1:0] i_req_burst_num,
  output logic [NUM_REQ-1:0]             o_req_ready,
  input  logic [NUM_REQ-1:0]             i_req_wr_valid,
  input  logic [NUM_REQ*8-1:0]           i_req_wr_byte,
  output logic [NUM_REQ-1:0]             o_req_wr_ready,
  output logic [NUM_REQ-1:0]             o_req_rd_valid,
  output logic [7:0]                     o_req_rd_byte,
  input  logic [NUM_REQ-1:0]             i_req_rd_ready,
  output logic [NUM_REQ-1:0]             o_req_err,
  output logic                           o_valid,
  output logic                           o_we,
  output logic                           o_sccb_mode,
  output logic [6:0]                     o_addr_slave,
  output logic [7:0]                     o_addr_reg,
  output logic [BURST_WIDTH-1:0]         o_burst_num,
  input  logic                           i_ready,
  output logic                           o_valid_wr_byte,
  output logic [7:0]                     o_wr_byte,
  input  logic                           i_ready_wr_byte,
  input  logic                           i_rd_valid,
  input  logic [7:0]                     i_rd_byte,
  output logic                           o_rd_ready,
  input  logic                           i_txn_abort,
  output logic [ID_W-1:0]                o_grant_id,
  output logic                           o_busy,
  output logic [1:0]                     o_dbg_state
);

  import i2c_cmd_arbiter_pkg::*;

  t_arb_states          state;
  logic [ID_W-1:0]      grant;
  logic [ID_W-1:0]      rr_ptr;
  logic [BURST_WIDTH:0] remaining;
  logic                 we_lat;
  logic [NUM_REQ-1:0]   err_q;

  logic [NUM_REQ-1:0]     pick_oh;
  logic [ID_W-1:0]        pick_idx;
  logic                   pick_any;
  logic                   sel_we;
  logic                   sel_sccb;
  logic [6:0]             sel_slave;
  logic [7:0]             sel_reg;
  logic [BURST_WIDTH-1:0] sel_burst;
  logic                   sel_wr_valid;
  logic [7:0]             sel_wr_byte;
  logic                   sel_rd_ready;
  logic [NUM_REQ-1:0]     grant_oh;
  logic                   beat;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req    (i_req_valid),
    .ptr    (rr_ptr),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Fields of the current owner, before any state gating.
  always_comb begin
    sel_we       = i_req_we[grant];
    sel_sccb     = i_req_sccb_mode[grant];
    sel_slave    = i_req_addr_slave[int'(grant)*7 +: 7];
    sel_reg      = i_req_addr_reg[int'(grant)*8 +: 8];
    sel_burst    = i_req_burst_num[int'(grant)*BURST_WIDTH +: BURST_WIDTH];
    sel_wr_valid = i_req_wr_valid[grant];
    sel_wr_byte  = i_req_wr_byte[int'(grant)*8 +: 8];
    sel_rd_ready = i_req_rd_ready[grant];
    grant_oh     = '0;
    grant_oh[grant] = 1'b1;
    beat = (state == DATA) &&
           (we_lat ? (sel_wr_valid && i_ready_wr_byte)
                   : (i_rd_valid && sel_rd_ready));
  end

  // Route command, write and read streams for the owner only; all else 0.
  always_comb begin
    o_valid         = 1'b0;
    o_we            = 1'b0;
    o_sccb_mode     = 1'b0;
    o_addr_slave    = '0;
    o_addr_reg      = '0;
    o_burst_num     = '0;
    o_req_ready     = '0;
    o_valid_wr_byte = 1'b0;
    o_wr_byte       = '0;
    o_req_wr_ready  = '0;
    o_req_rd_valid  = '0;
    o_req_rd_byte   = '0;
    o_rd_ready      = 1'b0;
    case (state)
      ISSUE: begin
        o_valid            = 1'b1;
        o_we               = sel_we;
        o_sccb_mode        = sel_sccb;
        o_addr_slave       = sel_slave;
        o_addr_reg         = sel_reg;
        o_burst_num        = sel_burst;
        o_req_ready[grant] = i_ready;
      end
      DATA: begin
        if (we_lat) begin
          o_valid_wr_byte       = sel_wr_valid;
          o_wr_byte             = sel_wr_byte;
          o_req_wr_ready[grant] = i_ready_wr_byte & sel_wr_valid;
        end else begin
          o_req_rd_valid[grant] = i_rd_valid;
          o_req_rd_byte         = i_rd_byte;
          o_rd_ready            = sel_rd_ready;
        end
      end
      default: ;
    endcase
  end

  assign o_req_err   = err_q;
  assign o_grant_id  = grant;
  assign o_busy      = (state != IDLE);
  assign o_dbg_state = state;

  // Arbitration FSM: grant, count beats, release and advance the pointer.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      grant     <= '0;
      rr_ptr    <= '0;
      remaining <= '0;
      we_lat    <= 1'b0;
      err_q     <= '0;
    end else begin
      err_q <= '0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            grant <= pick_idx;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (i_txn_abort) begin
            err_q <= grant_oh;
            state <= RELEASE;
          end else if (i_ready) begin
            // SCCB moves a single data byte regardless of burst_num.
            remaining <= sel_sccb ? (BURST_WIDTH+1)'(1)
                                  : {1'b0, sel_burst} + (BURST_WIDTH+1)'(1);
            we_lat    <= sel_we;
            state     <= DATA;
          end
        end
        DATA: begin
          if (beat) remaining <= remaining - (BURST_WIDTH+1)'(1);
          if (i_txn_abort) begin
            err_q <= grant_oh;
            state <= RELEASE;
          end else if (beat && remaining == (BURST_WIDTH+1)'(1)) begin
            state <= RELEASE;
          end
        end
        RELEASE: begin
          rr_ptr <= (grant == ID_W'(NUM_REQ-1)) ? '0 : grant + 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A requester must hold its command valid until the manager accepts it.
  a_valid_held: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (state == ISSUE) |-> i_req_valid[grant]);

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Self-checking bench for i2c_cmd_arbiter: directed table, continuous
// round-robin, randomized rounds against a transaction-level model, and a
// mid-transaction reset.
module tb_i2c_cmd_arbiter;

  localparam int N  = 4;
  localparam int BW = 4;
  localparam int IW = 2;

  // ---------------- clock / reset / signals ----------------
  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic [N-1:0]  i_req_valid, i_req_we, i_req_sccb_mode, i_req_wr_valid, i_req_rd_ready;
  logic [N*7-1:0]  i_req_addr_slave;
  logic [N*8-1:0]  i_req_addr_reg, i_req_wr_byte;
  logic [N*BW-1:0] i_req_burst_num;
  logic [N-1:0]  o_req_ready, o_req_wr_ready, o_req_rd_valid, o_req_err;
  logic [7:0]    o_req_rd_byte, o_addr_reg, o_wr_byte, i_rd_byte;
  logic          o_valid, o_we, o_sccb_mode, o_valid_wr_byte, o_rd_ready, o_busy;
  logic [6:0]    o_addr_slave;
  logic [BW-1:0] o_burst_num;
  logic          i_ready, i_ready_wr_byte, i_rd_valid, i_txn_abort;
  logic [IW-1:0] o_grant_id;
  logic [1:0]    o_dbg_state;

  always #5 i_clk = ~i_clk;

  i2c_cmd_arbiter #(.NUM_REQ(N), .BURST_WIDTH(BW), .ID_W(IW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req_valid(i_req_valid), .i_req_we(i_req_we), .i_req_sccb_mode(i_req_sccb_mode),
    .i_req_addr_slave(i_req_addr_slave), .i_req_addr_reg(i_req_addr_reg),
    .i_req_burst_num(i_req_burst_num), .o_req_ready(o_req_ready),
    .i_req_wr_valid(i_req_wr_valid), .i_req_wr_byte(i_req_wr_byte),
    .o_req_wr_ready(o_req_wr_ready), .o_req_rd_valid(o_req_rd_valid),
    .o_req_rd_byte(o_req_rd_byte), .i_req_rd_ready(i_req_rd_ready), .o_req_err(o_req_err),
    .o_valid(o_valid), .o_we(o_we), .o_sccb_mode(o_sccb_mode), .o_addr_slave(o_addr_slave),
    .o_addr_reg(o_addr_reg), .o_burst_num(o_burst_num), .i_ready(i_ready),
    .o_valid_wr_byte(o_valid_wr_byte), .o_wr_byte(o_wr_byte), .i_ready_wr_byte(i_ready_wr_byte),
    .i_rd_valid(i_rd_valid), .i_rd_byte(i_rd_byte), .o_rd_ready(o_rd_ready),
    .i_txn_abort(i_txn_abort), .o_grant_id(o_grant_id), .o_busy(o_busy),
    .o_dbg_state(o_dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  // Per-requester command: abort -1 none, -2 during ISSUE, k>=0 after k beats.
  bit c_we[N], c_sccb[N], c_abeat[N];
  int c_burst[N], c_abort[N];
  int model_ptr = 0;

  function automatic int full_beats(input int k);
    return c_sccb[k] ? 1 : c_burst[k] + 1;
  endfunction

  function automatic bit exp_err(input int k);
    return (c_abort[k] == -2) || (c_abort[k] >= 0 && c_abort[k] < full_beats(k));
  endfunction

  function automatic int exp_beats(input int k);
    if (c_abort[k] == -2) return 0;
    if (c_abort[k] >= 0 && c_abort[k] < full_beats(k)) return c_abort[k] + int'(c_abeat[k]);
    return full_beats(k);
  endfunction

  function automatic int pick(input logic [N-1:0] m, input int p);
    for (int i = 0; i < N; i++) if (m[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    i_req_valid = '0; i_req_we = '0; i_req_sccb_mode = '0; i_req_wr_valid = '0;
    i_req_rd_ready = '0; i_req_addr_slave = '0; i_req_addr_reg = '0; i_req_wr_byte = '0;
    i_req_burst_num = '0; i_ready = 0; i_ready_wr_byte = 0; i_rd_valid = 0;
    i_txn_abort = 0; i_rd_byte = 8'hA5;
  endtask

  task automatic set_cmd(input int k, input bit we, input bit sccb, input int burst,
                         input int ab, input bit abeat);
    c_we[k] = we; c_sccb[k] = sccb; c_burst[k] = burst; c_abort[k] = ab; c_abeat[k] = abeat;
    i_req_we[k] = we;
    i_req_sccb_mode[k] = sccb;
    i_req_burst_num[k*BW +: BW] = BW'(burst);
    i_req_addr_slave[k*7 +: 7] = 7'($urandom);
    i_req_addr_reg[k*8 +: 8] = 8'($urandom);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, int'(o_busy), 0);
    check({tag, "_grant"}, int'(o_grant_id), 0);
    check({tag, "_outputs"}, int'(|{o_req_ready, o_req_wr_ready, o_req_rd_valid, o_req_rd_byte,
          o_req_err, o_valid, o_we, o_sccb_mode, o_addr_slave, o_addr_reg, o_burst_num,
          o_valid_wr_byte, o_wr_byte, o_rd_ready, o_dbg_state}), 0);
  endtask

  task automatic do_reset();
    @(negedge i_clk); i_rst_n = 1'b0;
    @(negedge i_clk); #1;
    check_all_zero("rst");
    clear_inputs();
    @(negedge i_clk); i_rst_n = 1'b1; #1;
    model_ptr = 0;
  endtask

  // Serve one transaction for expected owner g, playing the manager side.
  task automatic serve(input int g, input bit keep, input bit chk_lat,
                       input int eb, input bit ee);
    int cyc, beats, bad_iso, bad_data, bad_grant, bad_stall, full;
    bit aborted, bm, we;
    logic [N-1:0] other;
    logic [20:0] exp_cmd;
    we = c_we[g];
    full = full_beats(g);
    other = ~(N'(1) << g);
    cyc = 0;
    do begin @(negedge i_clk); #1; cyc++; end while (!o_valid && cyc < 20);
    check("issue_seen", int'(o_valid), 1);
    if (chk_lat) check("issue_latency", cyc, 1);
    check("grant", int'(o_grant_id), g);
    exp_cmd = {c_we[g], c_sccb[g], i_req_addr_slave[g*7 +: 7], i_req_addr_reg[g*8 +: 8],
               BW'(c_burst[g])};
    check("cmd_fields", int'({o_we, o_sccb_mode, o_addr_slave, o_addr_reg, o_burst_num}),
          int'(exp_cmd));
    check("issue_ready_low", int'(o_req_ready), 0);
    bad_stall = 0;
    repeat ($urandom_range(0, 2)) begin
      @(negedge i_clk); #1;
      if (!o_valid || o_req_ready != 0 || o_grant_id != IW'(g)) bad_stall++;
    end
    check("issue_stall", bad_stall, 0);
    // command handshake (or abort while the command is pending)
    @(negedge i_clk);
    aborted = (c_abort[g] == -2);
    if (aborted) i_txn_abort = 1'b1; else i_ready = 1'b1;
    #1;
    if (!aborted) check("cmd_ready", int'(o_req_ready), 1 << g);
    // data beats with random stalls on both sides
    beats = 0; cyc = 0; bad_iso = 0; bad_data = 0; bad_grant = 0;
    while (!aborted && beats < full && cyc < 300) begin
      @(negedge i_clk);
      i_ready = 0; i_txn_abort = 0;
      if (!keep) i_req_valid[g] = 1'b0;
      i_req_wr_valid  = N'($urandom);
      i_req_rd_ready  = N'($urandom);
      i_req_wr_byte   = (N*8)'($urandom);
      i_rd_byte       = 8'($urandom);
      i_ready_wr_byte = we && ($urandom_range(0, 3) != 0);
      i_rd_valid      = !we && ($urandom_range(0, 3) != 0);
      if (c_abort[g] >= 0 && beats == c_abort[g]) begin
        i_txn_abort = 1'b1; aborted = 1'b1;
        if (we) begin
          i_req_wr_valid[g] = c_abeat[g];
          if (c_abeat[g]) i_ready_wr_byte = 1'b1;
        end else begin
          i_rd_valid = c_abeat[g];
          if (c_abeat[g]) i_req_rd_ready[g] = 1'b1;
        end
      end
      #1;
      if (((o_req_wr_ready | o_req_rd_valid | o_req_ready | o_req_err) & other) != 0) bad_iso++;
      if (o_grant_id != IW'(g) || !o_busy) bad_grant++;
      if (we) begin
        bm = i_req_wr_valid[g] & i_ready_wr_byte;
        if (o_req_wr_ready[g] != bm || o_valid_wr_byte != i_req_wr_valid[g] ||
            (o_valid_wr_byte && o_wr_byte != i_req_wr_byte[g*8 +: 8]) || o_req_rd_valid != 0)
          bad_data++;
      end else begin
        bm = i_rd_valid & i_req_rd_ready[g];
        if (o_req_rd_valid[g] != i_rd_valid || o_rd_ready != i_req_rd_ready[g] ||
            (i_rd_valid && o_req_rd_byte != i_rd_byte) || o_valid_wr_byte)
          bad_data++;
      end
      beats += int'(bm);
      cyc++;
    end
    check("data_in_time", int'(cyc < 300), 1);
    check("beats", beats, eb);
    check("isolation", bad_iso, 0);
    check("data_route", bad_data, 0);
    check("grant_hold", bad_grant, 0);
    // RELEASE: further beats offered must not be taken
    @(negedge i_clk);
    i_ready = 0; i_txn_abort = 0;
    if (!keep) i_req_valid[g] = 1'b0;
    i_req_wr_valid[g] = 1'b1; i_ready_wr_byte = 1'b1; i_rd_valid = 1'b1; i_req_rd_ready[g] = 1'b1;
    #1;
    check("release_busy", int'(o_busy), 1);
    check("release_err", int'(o_req_err), ee ? (1 << g) : 0);
    check("release_no_beat", int'({o_req_wr_ready, o_req_rd_valid, o_valid, o_rd_ready,
          o_valid_wr_byte}), 0);
    // IDLE gap
    @(negedge i_clk);
    i_req_wr_valid = '0; i_ready_wr_byte = 0; i_rd_valid = 0; i_req_rd_ready = '0;
    #1;
    check("idle_gap", int'(o_busy), 0);
    check("err_pulse_width", int'(o_req_err), 0);
    model_ptr = (g + 1) % N;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    int id; bit we; bit sccb; int burst; int abort_at; bit abeat; int exp_beats; bit exp_err;
  } vec_t;
  vec_t vecs[10];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end, expected completion");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] mask;
    int eg, cyc;
    i_rst_n = 1'b0;
    clear_inputs();
    vecs[0] = '{1, 1, 0, 2,  -1, 0, 3,  0};  // write, 3 bytes
    vecs[1] = '{2, 0, 0, 3,  -1, 0, 4,  0};  // read, 4 bytes
    vecs[2] = '{3, 1, 1, 5,  -1, 0, 1,  0};  // SCCB write -> 1 byte
    vecs[3] = '{0, 1, 0, 3,   1, 0, 1,  1};  // abort after 1 of 4
    vecs[4] = '{1, 0, 0, 0,  -1, 0, 1,  0};  // single-byte read
    vecs[5] = '{2, 1, 0, 15, -1, 0, 16, 0};  // maximum burst
    vecs[6] = '{0, 1, 0, 1,   1, 1, 2,  1};  // abort on the last beat
    vecs[7] = '{3, 0, 0, 2,  -2, 0, 0,  1};  // abort while command pending
    vecs[8] = '{1, 0, 1, 7,  -1, 0, 1,  0};  // SCCB read -> 1 byte
    vecs[9] = '{2, 1, 0, 2,   0, 0, 0,  1};  // abort before any beat

    do_reset();
    for (int i = 0; i < 10; i++) begin
      set_cmd(vecs[i].id, vecs[i].we, vecs[i].sccb, vecs[i].burst, vecs[i].abort_at, vecs[i].abeat);
      i_req_valid = N'(1) << vecs[i].id;
      serve(vecs[i].id, 1'b0, 1'b1, vecs[i].exp_beats, vecs[i].exp_err);
    end

    // all requesters continuously valid: order 0,1,2,3,0
    do_reset();
    for (int k = 0; k < N; k++) set_cmd(k, k[0], 1'b0, k, -1, 1'b0);
    i_req_valid = '1;
    for (int r = 0; r < 5; r++) begin
      eg = pick(i_req_valid, model_ptr);
      check("rr_order", eg, r % N);
      serve(eg, 1'b1, 1'b0, exp_beats(eg), exp_err(eg));
    end
    i_req_valid = '0;

    // randomized rounds against the model
    for (int r = 0; r < 25; r++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      for (int k = 0; k < N; k++) begin
        if (mask[k]) begin
          int b, ab;
          bit sc, w;
          b  = $urandom_range(0, 15);
          sc = ($urandom_range(0, 3) == 0);
          w  = 1'($urandom);
          ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, (sc ? 1 : b + 1) + 1)) - 2 : -1;
          set_cmd(k, w, sc, b, ab, 1'($urandom));
        end
      end
      i_req_valid = mask;
      while (mask != 0) begin
        eg = pick(mask, model_ptr);
        serve(eg, 1'b0, 1'b0, exp_beats(eg), exp_err(eg));
        mask[eg] = 1'b0;
      end
    end

    // reset in the middle of a read transaction
    do_reset();
    set_cmd(2, 1'b1, 1'b0, 1, -1, 1'b0);
    i_req_valid = 4'b0100;
    serve(2, 1'b0, 1'b1, 2, 1'b0);
    set_cmd(1, 1'b0, 1'b0, 3, -1, 1'b0);
    i_req_valid = 4'b0010;
    cyc = 0;
    do begin @(negedge i_clk); #1; cyc++; end while (!o_valid && cyc < 20);
    check("rst_seq_grant", int'(o_grant_id), 1);
    @(negedge i_clk); i_ready = 1'b1;
    @(negedge i_clk); i_ready = 1'b0; i_req_valid = '0;
    i_rd_valid = 1'b1; i_req_rd_ready = 4'b0010; i_rd_byte = 8'h3C; #1;
    check("rst_seq_rd_valid", int'(o_req_rd_valid), 4'b0010);
    @(negedge i_clk); #1;
    check("rst_seq_busy", int'(o_busy), 1);
    i_rst_n = 1'b0;
    @(negedge i_clk); #1;
    check_all_zero("mid_rst");
    clear_inputs();
    @(negedge i_clk); i_rst_n = 1'b1; #1;
    model_ptr = 0;
    // pointer must restart at 0: requesters 0 and 3 together pick 0
    set_cmd(0, 1'b1, 1'b0, 0, -1, 1'b0);
    set_cmd(3, 1'b0, 1'b0, 1, -1, 1'b0);
    mask = 4'b1001;
    i_req_valid = mask;
    while (mask != 0) begin
      eg = pick(mask, model_ptr);
      serve(eg, 1'b0, 1'b0, exp_beats(eg), exp_err(eg));
      mask[eg] = 1'b0;
    end
    set_cmd(2, 1'b0, 1'b0, 2, -1, 1'b0);
    i_req_valid = 4'b0100;
    serve(2, 1'b0, 1'b1, 3, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/i2c_cmd_arbiter.md
Name: i2c_cmd_arbiter

Overview:
- Round-robin arbiter sharing one I2C request manager (command, write-byte and read-byte streams) between NUM_REQ requesters, e.g. a sensor init sequencer, a frame-readout engine and a debug UART bridge.
- Locks the grant for a whole transaction: command handshake plus all data bytes, or an abort.
- Routes the write bytes from the granted requester and the read bytes back to it.
- Sits between the requester-side FIFOs and the request manager's CMD/WR/RD FIFO ports.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- BURST_WIDTH, 4, burst count width; must match the request manager
- ID_W, $clog2(NUM_REQ), grant index width

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  synchronous active-low reset
- i_req_valid  in  NUM_REQ  per-requester command valid
- i_req_we  in  NUM_REQ  1=write transaction
- i_req_sccb_mode  in  NUM_REQ  SCCB mode flag
- i_req_addr_slave  in  NUM_REQ*7  slave addresses, requester k at [7k+:7]
- i_req_addr_reg  in  NUM_REQ*8  register addresses
- i_req_burst_num  in  NUM_REQ*BURST_WIDTH  burst counts (bytes = n+1)
- o_req_ready  out  NUM_REQ  command accepted
- i_req_wr_valid  in  NUM_REQ  write byte valid
- i_req_wr_byte  in  NUM_REQ*8  write bytes
- o_req_wr_ready  out  NUM_REQ  write byte popped
- o_req_rd_valid  out  NUM_REQ  read byte valid
- o_req_rd_byte  out  8  shared read data
- i_req_rd_ready  in  NUM_REQ  requester can take read byte
- o_req_err  out  NUM_REQ  1-cycle pulse: transaction aborted
- o_valid  out  1  command valid to manager
- o_we, o_sccb_mode  out  1 each  muxed command fields
- o_addr_slave  out  7  muxed slave address
- o_addr_reg  out  8  muxed register address
- o_burst_num  out  BURST_WIDTH  muxed burst count
- i_ready  in  1  manager command ready
- o_valid_wr_byte  out  1  write byte valid to manager
- o_wr_byte  out  8  write byte to manager
- i_ready_wr_byte  in  1  manager pops write byte
- i_rd_valid  in  1  read byte from manager
- i_rd_byte  in  8  read data
- o_rd_ready  out  1  read byte accepted
- i_txn_abort  in  1  manager NACK/stop-abort pulse
- o_grant_id  out  ID_W  current owner
- o_busy  out  1  grant held (state != IDLE)

Behaviour:
- State machine: IDLE, ISSUE, DATA, RELEASE.
- Registered state: state, grant (ID_W), rr_ptr (ID_W), remaining (BURST_WIDTH+1 bits), we_lat.
- Reset (i_rst_n=0 at a clock edge, also mid-transaction): state=IDLE, grant=0, rr_ptr=0, remaining=0. All outputs are 0 the cycle after.
- Reset does not notify the manager; the system resets both together.
- IDLE:
  - If any i_req_valid, pick the first set bit searching from rr_ptr upward, wrapping NUM_REQ-1 to 0.
  - grant is registered; go to ISSUE. Grant is visible 1 cycle after valid is seen.
- ISSUE:
  - o_valid=1; command fields are the combinational mux of the granted requester.
  - o_req_ready[grant] = i_ready (pass-through); all other ready bits 0.
  - On i_ready: remaining = (sccb ? 0 : burst_num) + 1; we_lat = we; go to DATA.
- DATA, write (we_lat=1):
  - o_valid_wr_byte = i_req_wr_valid[grant]; o_wr_byte = mux; o_req_wr_ready[grant] = i_ready_wr_byte & valid.
- DATA, read:
  - o_req_rd_valid[grant] = i_rd_valid; o_req_rd_byte = i_rd_byte; o_rd_ready = i_req_rd_ready[grant].
- DATA, counting and exit:
  - remaining decrements on each completed beat.
  - The beat that takes remaining 1 to 0 moves the FSM to RELEASE.
- RELEASE (1 cycle): rr_ptr = (grant==NUM_REQ-1) ? 0 : grant+1; go to IDLE.
  - Minimum gap between grants is 2 cycles, which stops a requester from chaining.
- Abort:
  - i_txn_abort in ISSUE or DATA: o_req_err[grant] pulses the next cycle; go to RELEASE; unsent write bytes stay in the requester FIFO.
  - Abort coincident with the last beat: the beat completes and the err pulse still fires.
  - Abort in IDLE/RELEASE is ignored.
- Non-granted requesters always see ready/valid = 0.
- Requester valid dropping in ISSUE is a protocol violation; the FSM stays in ISSUE. This is covered by assertion only.
- burst_num = 2^BURST_WIDTH-1 gives remaining = 2^BURST_WIDTH; no overflow, due to the extra bit.
- o_busy = (state != IDLE).

Decomposition:
- package_i2c gains:
  - t_arb_states enum (IDLE, ISSUE, DATA, RELEASE)
  - t_i2c_cmd packed struct {we, sccb_mode, addr_slave[6:0], addr_reg[7:0], burst_num}; BURST_WIDTH is a package localparam shared with i2c_req_manager_8bit.
- Sub-module rr_priority_pick (NUM_REQ): combinational request vector + pointer -> one-hot/index + any. It is reusable and unit-tested separately.

Test Plan:
- Single requester 1, write, burst_num=2: ISSUE 1 cycle after valid, 3 wr bytes popped only from req 1, then RELEASE, IDLE, rr_ptr=2.
- All 4 valid continuously: grant order 0,1,2,3,0; no grant changes while o_busy=1.
- Read, burst_num=3, i_req_rd_ready toggled: exactly 4 bytes delivered to owner; stalls honoured; o_rd_ready follows owner ready.
- SCCB write with burst_num=5: remaining=1; exactly 1 wr byte popped.
- i_txn_abort after 1 of 4 write bytes: o_req_err[owner] 1-cycle pulse; 3 bytes left unpopped; next requester granted.
- i_rst_n low mid-DATA: all outputs 0 next cycle; rr_ptr=0; the following request from req 2 is granted normally.
